// File: rtl/scan_ctrl.sv
// scan_ctrl: sequences capture, shift and update of an on-chip scan chain
// using two-phase non-overlapping scan clocks derived from the system clock.
module scan_ctrl #(
  parameter int CHAIN_LEN = 64,
  parameter int DIV = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CHAIN_LEN-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 scan_phi,
  output logic                 scan_phi_bar,
  output logic                 scan_data_in,
  input  logic                 scan_data_out,
  output logic                 scan_load_chain,
  output logic                 scan_load_chip
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(CHAIN_LEN - 1);
  localparam logic [2:0] IDLE = 3'd0, CAPTURE = 3'd1, SHIFT = 3'd2, LOADCHIP = 3'd3, RESP = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [CHAIN_LEN-1:0] data_q, data_d, rsp_q, rsp_d;
  logic [DW-1:0]        div_q, div_d;
  logic [1:0]           seg_q, seg_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 phi_q, phi_d, phib_q, phib_d, sdi_q, sdi_d;
  logic                 lchain_q, lchain_d, lchip_q, lchip_d;
  logic                 seg_end, tick_end, scanning;

  assign seg_end  = div_q == DIV_MAX;
  assign tick_end = seg_end && seg_q == 2'd3;
  assign scanning = state_d == CAPTURE || state_d == SHIFT;

  // Pads are registered from next-state values so they are glitch-free and
  // line up exactly with the segment the FSM is in.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    div_d   = div_q;
    seg_d   = seg_q;
    bit_d   = bit_q;
    if (state_q == IDLE) begin
      if (cmd_valid) begin
        op_d    = cmd_op;
        data_d  = cmd_data;
        div_d   = '0;
        seg_d   = '0;
        bit_d   = '0;
        state_d = cmd_op[0] ? CAPTURE : SHIFT;
      end
    end else if (state_q == RESP) begin
      state_d = rsp_ready ? IDLE : RESP;
    end else begin
      div_d = seg_end ? '0 : div_q + DW'(1);
      seg_d = seg_end ? seg_q + 2'd1 : seg_q;
      if (state_q == SHIFT && seg_q == 2'd0 && seg_end)
        rsp_d = {scan_data_out, rsp_q[CHAIN_LEN-1:1]};
      if (state_q == CAPTURE && tick_end)
        state_d = SHIFT;
      if (state_q == SHIFT && tick_end) begin
        data_d = data_q >> 1;
        bit_d  = bit_q + BW'(1);
        if (bit_q == BIT_MAX)
          state_d = op_q[1] ? LOADCHIP : RESP;
      end
      if (state_q == LOADCHIP && seg_q == 2'd2 && seg_end) begin
        seg_d   = '0;
        state_d = RESP;
      end
    end
    phi_d    = scanning && seg_d == 2'd1;
    phib_d   = scanning && seg_d == 2'd3;
    lchain_d = state_d == CAPTURE;
    sdi_d    = state_d == SHIFT && data_d[0];
    lchip_d  = state_d == LOADCHIP && seg_d == 2'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      data_q   <= '0;
      rsp_q    <= '0;
      div_q    <= '0;
      seg_q    <= '0;
      bit_q    <= '0;
      phi_q    <= 1'b0;
      phib_q   <= 1'b0;
      sdi_q    <= 1'b0;
      lchain_q <= 1'b0;
      lchip_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      rsp_q    <= rsp_d;
      div_q    <= div_d;
      seg_q    <= seg_d;
      bit_q    <= bit_d;
      phi_q    <= phi_d;
      phib_q   <= phib_d;
      sdi_q    <= sdi_d;
      lchain_q <= lchain_d;
      lchip_q  <= lchip_d;
    end
  end

  assign cmd_ready       = state_q == IDLE;
  assign rsp_valid       = state_q == RESP;
  assign rsp_data        = rsp_q;
  assign scan_phi        = phi_q;
  assign scan_phi_bar    = phib_q;
  assign scan_data_in    = sdi_q;
  assign scan_load_chain = lchain_q;
  assign scan_load_chip  = lchip_q;
endmodule

// File: tb/tb_scan_ctrl.sv
// tb_scan_ctrl: drives scan_ctrl against a behavioural chip chain and a
// command-level scoreboard, with pad-timing monitors running throughout.
module tb_scan_ctrl;
  localparam int N = 8;
  localparam int DIV = 1;

  logic         clock = 1'b0, reset = 1'b1;
  logic         cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic [1:0]   cmd_op = '0;
  logic [N-1:0] cmd_data = '0;
  logic         cmd_ready, rsp_valid;
  logic [N-1:0] rsp_data;
  logic         scan_phi, scan_phi_bar, scan_data_in, scan_data_out, scan_load_chain, scan_load_chip;
  int           asserts = 0, fails = 0;

  always #5 clock = ~clock;

  scan_ctrl #(.CHAIN_LEN(N), .DIV(DIV)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .scan_phi(scan_phi), .scan_phi_bar(scan_phi_bar), .scan_data_in(scan_data_in),
    .scan_data_out(scan_data_out), .scan_load_chain(scan_load_chain), .scan_load_chip(scan_load_chip)
  );

  // Chip model: master latches on scan_phi, slave (chain) on scan_phi_bar.
  logic [N-1:0] chain = '0, master = '0, chip_reg = '0, chip_in = '0;
  int           chip_pulses = 0;
  logic         phi_p = 1'b0, phib_p = 1'b0, lchip_p = 1'b0, sdi_p = 1'b0, lc_p = 1'b0;
  int           cyc = 0, phi_edge = -100, phib_edge = -100, stable = 0;
  bit           win = 1'b0;
  bit           sdi_seq[$];
  logic [N-1:0] exp_chain = '0;
  bit           exp_known = 1'b1;

  assign scan_data_out = chain[0];

  always @(negedge clock) begin
    cyc++;
    if (scan_phi && !phi_p) master = scan_load_chain ? chip_in : {scan_data_in, chain[N-1:1]};
    if (scan_phi_bar && !phib_p) chain = master;
    if (scan_load_chip && !lchip_p) begin
      chip_reg = chain;
      chip_pulses++;
    end
    if (!scan_phi_bar && phib_p) win = 1'b0;
    stable = (scan_data_in !== sdi_p || scan_load_chain !== lc_p) ? 1 : stable + 1;
    if (scan_phi || scan_phi_bar) begin
      asserts++;
      if (scan_phi && scan_phi_bar) begin
        fails++;
        $display("FAIL overlap: phi=%b phi_bar=%b at cycle %0d, required not both high", scan_phi, scan_phi_bar, cyc);
      end
    end
    if (reset) win = 1'b0;
    else begin
      if (win) begin
        asserts++;
        if (stable == 1) begin
          fails++;
          $display("FAIL stability: data_in/load_chain changed mid-tick at cycle %0d", cyc);
        end
      end
      if (scan_phi && !phi_p) begin
        asserts++;
        if (cyc - phib_edge < DIV || stable < DIV + 1) begin
          fails++;
          $display("FAIL phi_rise: gap=%0d stable=%0d at cycle %0d, required >=%0d and >=%0d",
                   cyc - phib_edge, stable, cyc, DIV, DIV + 1);
        end
        win = 1'b1;
        if (!scan_load_chain) sdi_seq.push_back(scan_data_in);
      end
      if (scan_phi_bar && !phib_p) begin
        asserts++;
        if (cyc - phi_edge < DIV) begin
          fails++;
          $display("FAIL phib_rise: gap=%0d at cycle %0d, required >=%0d", cyc - phi_edge, cyc, DIV);
        end
      end
    end
    if (scan_phi !== phi_p) phi_edge = cyc;
    if (scan_phi_bar !== phib_p) phib_edge = cyc;
    phi_p   = scan_phi;
    phib_p  = scan_phi_bar;
    lchip_p = scan_load_chip;
    sdi_p   = scan_data_in;
    lc_p    = scan_load_chain;
  end

  function automatic bit pads_idle();
    return !scan_phi && !scan_phi_bar && !scan_data_in && !scan_load_chain && !scan_load_chip;
  endfunction

  task automatic check_idle(input string name);
    asserts++;
    if (!pads_idle() || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== '0) begin
      fails++;
      $display("FAIL %s: pads=%b%b%b%b%b ready=%b rsp_valid=%b rsp_data=%h, required 00000 1 0 00",
               name, scan_phi, scan_phi_bar, scan_data_in, scan_load_chain, scan_load_chip,
               cmd_ready, rsp_valid, rsp_data);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [N-1:0] data, input logic [N-1:0] chip,
                         input int hold, input string name);
    int n, exp_lat, pulses0;
    logic [N-1:0] exp_rsp, got, seqv;
    exp_rsp = op[0] ? chip : exp_chain;
    exp_lat = 4 * DIV * (N + int'(op[0])) + 3 * DIV * int'(op[1]) + 1;
    chip_in = chip;
    pulses0 = chip_pulses;
    sdi_seq.delete();
    @(negedge clock);
    asserts++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s ready: cmd_ready=%b, required 1", name, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = data;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_data = N'($urandom);
    n = 1;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    asserts++;
    if (n != exp_lat) begin
      fails++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, n, exp_lat);
    end
    got = rsp_data;
    if (exp_known) begin
      asserts++;
      if (got !== exp_rsp) begin
        fails++;
        $display("FAIL %s rsp_data: got %h, required %h", name, got, exp_rsp);
      end
    end
    for (int i = 0; i < hold; i++) begin
      cmd_valid = i[0];
      cmd_op = 2'($urandom);
      cmd_data = N'($urandom);
      @(negedge clock);
      asserts++;
      if (rsp_valid !== 1'b1 || rsp_data !== got || cmd_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s hold: rsp_valid=%b rsp_data=%h cmd_ready=%b, required 1 %h 0",
                 name, rsp_valid, rsp_data, cmd_ready, got);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    asserts++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s return: rsp_valid=%b cmd_ready=%b, required 0 1", name, rsp_valid, cmd_ready);
    end
    if (hold > 0)
      for (int i = 0; i < 6; i++) begin
        @(negedge clock);
        asserts++;
        if (cmd_ready !== 1'b1 || !pads_idle()) begin
          fails++;
          $display("FAIL %s ignored: cmd_ready=%b phi=%b, required 1 0", name, cmd_ready, scan_phi);
        end
      end
    seqv = '0;
    foreach (sdi_seq[k]) if (k < N) seqv[k] = sdi_seq[k];
    asserts++;
    if (sdi_seq.size() != N || seqv !== data) begin
      fails++;
      $display("FAIL %s data_in_seq: got %0d bits %b, required %0d bits %b (LSB first)",
               name, sdi_seq.size(), seqv, N, data);
    end
    asserts++;
    if (chip_pulses - pulses0 != int'(op[1])) begin
      fails++;
      $display("FAIL %s load_chip_pulses: got %0d, required %0d", name, chip_pulses - pulses0, op[1]);
    end
    if (op[1]) begin
      asserts++;
      if (chip_reg !== data) begin
        fails++;
        $display("FAIL %s chip_reg: got %h, required %h", name, chip_reg, data);
      end
    end
    exp_chain = data;
    exp_known = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_idle("reset_held");
    end
    reset = 1'b0;
    @(negedge clock);
    check_idle("reset_after");
  endtask

  task automatic test_update();
    run_cmd(2'b10, 8'hA5, N'($urandom), 0, "update");
  endtask

  task automatic test_capture();
    run_cmd(2'b01, N'($urandom), 8'h3C, 0, "capture");
  endtask

  task automatic test_capture_update();
    run_cmd(2'b11, 8'hFF, 8'h12, 0, "capture_update");
  endtask

  task automatic test_shift_only();
    run_cmd(2'b00, N'($urandom), N'($urandom), 0, "shift_only");
  endtask

  task automatic test_hold();
    run_cmd(2'($urandom), N'($urandom), N'($urandom), 10, "hold");
  endtask

  task automatic test_reset_mid();
    int n, pulses0;
    chip_in = N'($urandom);
    sdi_seq.delete();
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op = 2'b10;
    cmd_data = N'($urandom);
    @(negedge clock);
    cmd_valid = 1'b0;
    n = 0;
    while (sdi_seq.size() < 5 && n < 100) begin
      @(negedge clock);
      n++;
    end
    asserts++;
    if (n >= 100) begin
      fails++;
      $display("FAIL reset_mid timeout: shift tick 4 not reached, got %0d ticks, required 5", sdi_seq.size());
    end
    pulses0 = chip_pulses;
    reset = 1'b1;
    @(negedge clock);
    asserts++;
    if (!pads_idle() || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid pads: phi=%b phib=%b sdi=%b rsp_valid=%b ready=%b, required 0 0 0 0 1",
               scan_phi, scan_phi_bar, scan_data_in, rsp_valid, cmd_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      asserts++;
      if (rsp_valid !== 1'b0 || !pads_idle()) begin
        fails++;
        $display("FAIL reset_mid aborted: rsp_valid=%b phi=%b, required 0 0", rsp_valid, scan_phi);
      end
    end
    asserts++;
    if (chip_pulses != pulses0) begin
      fails++;
      $display("FAIL reset_mid load_chip: got %0d pulses, required 0", chip_pulses - pulses0);
    end
    exp_known = 1'b0;
    run_cmd(2'b10, N'($urandom), N'($urandom), 0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_cmd(2'($urandom), N'($urandom), N'($urandom), int'($urandom_range(0, 3)), "random");
  endtask

  initial begin
    test_reset();
    test_update();
    test_capture();
    test_capture_update();
    test_shift_only();
    test_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
